// File: rtl/seg7_scan_decoder.sv
// Scan-bus receiver for a multiplexed 7-segment display. It decodes each settled digit back
// to BCD and assembles MM:SS frames into binary minutes and seconds.
module seg7_scan_decoder #(
    parameter int STABLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [6:0]  ca,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic [5:0]  sec,
    output logic [5:0]  min,
    output logic        frame_done,
    output logic        err_seg,
    output logic        err_an,
    output logic        stale,
    output logic        frame_state
);
    localparam int CW = $clog2(STABLE_CYC + 1);

    typedef enum logic {COLLECT = 1'b0, EMIT = 1'b1} frame_state_t;

    frame_state_t  state, state_next;
    logic [3:0]    an_q, an_p, an_low;
    logic [6:0]    ca_q, ca_p;
    logic [CW-1:0] stable_cnt;
    logic [31:0]   idle_cnt;
    logic          changed, accept_pt, blank, multi_an, pat_ok, digit_acc, timed_out;
    logic [1:0]    pos;
    logic [3:0]    bcd, valid_next;

    function automatic logic [5:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] ones);
        if (tens > 4'd5) return 6'd59;
        return {2'b00, tens} * 6'd10 + {2'b00, ones};
    endfunction

    assign changed   = {an_q, ca_q} != {an_p, ca_p};
    // The counter saturates above STABLE_CYC-1, so this point is hit once per stable window.
    assign accept_pt = !changed && (stable_cnt == CW'(STABLE_CYC - 1));
    assign blank     = an_q == 4'hF;
    assign an_low    = ~an_q;
    assign multi_an  = (an_low & (an_low - 4'd1)) != 4'd0;
    assign digit_acc = accept_pt && !blank && !multi_an && pat_ok;
    assign timed_out = idle_cnt >= 32'(TIMEOUT_CYC);
    assign frame_state = state;

    always_comb begin
        pos = 2'd0;
        case (an_q)
            4'b1110: pos = 2'd0;
            4'b1101: pos = 2'd1;
            4'b1011: pos = 2'd2;
            4'b0111: pos = 2'd3;
            default: pos = 2'd0;
        endcase
    end

    always_comb begin
        pat_ok = 1'b1;
        bcd    = 4'd0;
        case (ca_q)
            7'h01: bcd = 4'd0;
            7'h4F: bcd = 4'd1;
            7'h12: bcd = 4'd2;
            7'h06: bcd = 4'd3;
            7'h4C: bcd = 4'd4;
            7'h24: bcd = 4'd5;
            7'h20: bcd = 4'd6;
            7'h0F: bcd = 4'd7;
            7'h00: bcd = 4'd8;
            7'h0C: bcd = 4'd9;
            default: pat_ok = 1'b0;
        endcase
    end

    // A digit accepted during EMIT starts the next frame, so its bit is set after the clear.
    always_comb begin
        valid_next = digit_valid;
        state_next = COLLECT;
        if (state == EMIT || (timed_out && !digit_acc)) valid_next = 4'h0;
        if (digit_acc) valid_next = valid_next | (4'b0001 << pos);
        if (state == COLLECT && !(timed_out && !digit_acc) && valid_next == 4'hF)
            state_next = EMIT;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            an_q        <= 4'hF;
            an_p        <= 4'hF;
            ca_q        <= 7'h7F;
            ca_p        <= 7'h7F;
            stable_cnt  <= '0;
            idle_cnt    <= '0;
            state       <= COLLECT;
            digits      <= '0;
            digit_valid <= '0;
            sec         <= '0;
            min         <= '0;
            frame_done  <= 1'b0;
            err_seg     <= 1'b0;
            err_an      <= 1'b0;
            stale       <= 1'b0;
        end else begin
            an_q <= an;
            ca_q <= ca;
            an_p <= an_q;
            ca_p <= ca_q;
            if (changed) stable_cnt <= '0;
            else if (stable_cnt != CW'(STABLE_CYC)) stable_cnt <= stable_cnt + 1'b1;
            if (digit_acc) idle_cnt <= '0;
            else if (idle_cnt != 32'hFFFF_FFFF) idle_cnt <= idle_cnt + 32'd1;

            state       <= state_next;
            digit_valid <= valid_next;
            if (digit_acc) digits[{pos, 2'b00} +: 4] <= bcd;
            if (state == EMIT) begin
                sec <= bcd_to_bin(digits[7:4], digits[3:0]);
                min <= bcd_to_bin(digits[15:12], digits[11:8]);
            end
            frame_done <= state == EMIT;

            if (accept_pt && !blank && multi_an) err_an <= 1'b1;
            if (accept_pt && !blank && !multi_an && (!pat_ok || (pos[0] && bcd > 4'd5)))
                err_seg <= 1'b1;
            if (digit_acc) stale <= 1'b0;
            else if (timed_out) stale <= 1'b1;
        end
    end
endmodule
